avmm_cycle_timer: RTL



---
 rtl/avmm_timer_pkg.sv | 44 ++++
 rtl/cycle_counter64.sv | 65 ++++++
 rtl/avmm_cycle_timer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/avmm_timer_pkg.sv
// Register map, CTRL bit positions and small helpers shared by the
// Avalon-MM cycle timer and its counter core.
package avmm_timer_pkg;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h7EC3_0001;
    localparam int          CNT_W_DEFAULT    = 64;

    localparam logic [2:0] ADDR_CTRL    = 3'd0;
    localparam logic [2:0] ADDR_CNT_LO  = 3'd1;
    localparam logic [2:0] ADDR_CNT_HI  = 3'd2;
    localparam logic [2:0] ADDR_CMP_LO  = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH = 3'd4;
    localparam logic [2:0] ADDR_ID      = 3'd5;

    // Command bits in a CTRL write (byte lane 0 only)
    localparam int CTRL_START   = 0;
    localparam int CTRL_STOP    = 1;
    localparam int CTRL_CLEAR   = 2;
    localparam int CTRL_IRQ_ACK = 3;

    // Status bits seen on a CTRL read; packed order gives running at bit 0
    typedef struct packed {
        logic irq_pending;
        logic overflow;
        logic running;
    } timer_status_t;

    function automatic logic [31:0] status_word(input timer_status_t s);
        status_word = {29'd0, s};
    endfunction

    function automatic logic [31:0] be_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = be[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cycle_counter64.sv
// 64-bit free-running counter with start/stop/clear control and a sticky
// wrap flag. STOP beats START, CLEAR beats counting and wrap.
module cycle_counter64
    import avmm_timer_pkg::*;
#(
    parameter int           W    = CNT_W_DEFAULT,
    parameter logic [W-1:0] INIT = '0
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_start,
    input  logic         i_stop,
    input  logic         i_clear,
    output logic [W-1:0] o_count,
    output logic         o_running,
    output logic         o_overflow,
    output logic         o_step
);

    logic [W-1:0] r_count;
    logic         r_running;
    logic         r_overflow;
    logic         w_step;
    logic         w_wrap;

    // A STOP arriving on an edge suppresses the increment on that same edge
    assign w_step = r_running & ~i_stop & ~i_clear;
    assign w_wrap = w_step & (&r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= INIT;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (w_step) begin
            r_count <= r_count + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_running <= 1'b0;
        end else if (i_stop) begin
            r_running <= 1'b0;
        end else if (i_start) begin
            r_running <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_overflow <= 1'b0;
        end else if (w_wrap) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_count    = r_count;
    assign o_running  = r_running;
    assign o_overflow = r_overflow;
    assign o_step     = w_step;

endmodule

// File: rtl/avmm_cycle_timer.sv
// Avalon-MM cycle timer: 64-bit counter, coherent LO/HI readout through a
// shadow, compare interrupt on the low word, scratch and ID registers.
module avmm_cycle_timer
    import avmm_timer_pkg::*;
#(
    parameter logic [31:0]      ID_VALUE = ID_VALUE_DEFAULT,
    parameter int               CNT_W    = CNT_W_DEFAULT,
    // Counter value after reset; nonzero starts the count just short of a carry or wrap
    parameter logic [CNT_W-1:0] CNT_INIT = '0
)(
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        avs_waitrequest,
    output logic        irq
);

    logic             w_wr;
    logic             w_rd;
    logic             w_ctrl_wr;
    logic             w_start;
    logic             w_stop;
    logic             w_clear;
    logic             w_ack;
    logic [CNT_W-1:0] w_count;
    logic             w_running;
    logic             w_overflow;
    logic             w_step;
    logic [31:0]      w_lo_next;
    logic             w_cmp_hit;
    logic [31:0]      w_rdata;
    timer_status_t    w_status;

    logic [31:0]      r_shadow;
    logic [31:0]      r_cmp_lo;
    logic [31:0]      r_scratch;
    logic             r_irq_pending;
    logic [31:0]      r_rdata;
    logic             r_rdv;

    // Valid/ready: waitrequest is never raised, so a request is accepted on the
    // edge where it is presented; a read answers with a one-cycle readdatavalid
    // on the next cycle. Read and write together is resolved as a write.
    assign w_wr = avs_write;
    assign w_rd = avs_read & ~avs_write;

    assign w_ctrl_wr = w_wr && (avs_address == ADDR_CTRL) && avs_byteenable[0];
    assign w_start   = w_ctrl_wr & avs_writedata[CTRL_START];
    assign w_stop    = w_ctrl_wr & avs_writedata[CTRL_STOP];
    assign w_clear   = w_ctrl_wr & avs_writedata[CTRL_CLEAR];
    assign w_ack     = w_ctrl_wr & avs_writedata[CTRL_IRQ_ACK];

    cycle_counter64 #(
        .W    (CNT_W),
        .INIT (CNT_INIT)
    ) u_counter (
        .clk        (clk_50),
        .rst_n      (reset_n),
        .i_start    (w_start),
        .i_stop     (w_stop),
        .i_clear    (w_clear),
        .o_count    (w_count),
        .o_running  (w_running),
        .o_overflow (w_overflow),
        .o_step     (w_step)
    );

    // Compare against the value the low word takes on this edge
    assign w_lo_next = w_count[31:0] + 32'd1;
    assign w_cmp_hit = w_step && (w_lo_next == r_cmp_lo);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_pending <= 1'b0;
        end else if (w_cmp_hit) begin
            r_irq_pending <= 1'b1;
        end else if (w_clear || w_ack) begin
            r_irq_pending <= 1'b0;
        end
    end

    // A LO read captures the pre-increment high word so the HI read cannot tear
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow <= '0;
        end else if (w_clear) begin
            r_shadow <= '0;
        end else if (w_rd && (avs_address == ADDR_CNT_LO)) begin
            r_shadow <= w_count[CNT_W-1:32];
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_cmp_lo  <= '0;
            r_scratch <= '0;
        end else if (w_wr) begin
            if (avs_address == ADDR_CMP_LO) begin
                r_cmp_lo <= be_merge(r_cmp_lo, avs_writedata, avs_byteenable);
            end
            if (avs_address == ADDR_SCRATCH) begin
                r_scratch <= be_merge(r_scratch, avs_writedata, avs_byteenable);
            end
        end
    end

    assign w_status.irq_pending = r_irq_pending;
    assign w_status.overflow    = w_overflow;
    assign w_status.running     = w_running;

    always_comb begin
        w_rdata = '0;
        case (avs_address)
            ADDR_CTRL:    w_rdata = status_word(w_status);
            ADDR_CNT_LO:  w_rdata = w_count[31:0];
            ADDR_CNT_HI:  w_rdata = r_shadow;
            ADDR_CMP_LO:  w_rdata = r_cmp_lo;
            ADDR_SCRATCH: w_rdata = r_scratch;
            ADDR_ID:      w_rdata = ID_VALUE;
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_rdv   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_rdv   <= w_rd;
            r_rdata <= w_rd ? w_rdata : 32'd0;
        end
    end

    assign avs_readdata      = r_rdata;
    assign avs_readdatavalid = r_rdv;
    assign avs_waitrequest   = 1'b0;
    assign irq               = r_irq_pending;

endmodule
